// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command-driven controller for a bank of JK flip-flops with readback check
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q_snap
);
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, CHECK} state_t;
  localparam logic [2:0] OP_HOLD = 3'd0, OP_SET = 3'd1, OP_CLEAR = 3'd2,
                         OP_TOGGLE = 3'd3, OP_LOAD = 3'd4, OP_COUNT = 3'd5;
  localparam logic [WIDTH-1:0] ZERO = '0;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d, data_q, data_d, q_pre_q, q_pre_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, q_snap_q, q_snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  // {j,k} for one APPLY cycle; COUNT toggles bit i only when all lower bits are 1
  function automatic logic [2*WIDTH-1:0] jk_f(input logic [2:0] op,
      input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] qv);
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) t[i] = t[i-1] & qv[i-1];
    return op == OP_SET    ? {m, ZERO} :
           op == OP_CLEAR  ? {ZERO, m} :
           op == OP_TOGGLE ? {m, m} :
           op == OP_LOAD   ? {m & d, m & ~d} :
           op == OP_COUNT  ? {m & t, m & t} : {ZERO, ZERO};
  endfunction
  // value the bank must show after the command, given the pre-command snapshot
  function automatic logic [WIDTH-1:0] exp_f(input logic [2:0] op,
      input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] qp);
    return op == OP_SET    ? qp | m :
           op == OP_CLEAR  ? qp & ~m :
           op == OP_TOGGLE ? qp ^ m :
           op == OP_LOAD   ? (qp & ~m) | (d & m) : qp;
  endfunction
  // next-state logic; j/k/done/err are computed one edge ahead so they leave flops
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    mask_d = mask_q;
    data_d = data_q;
    q_pre_d = q_pre_q;
    cnt_d = cnt_q;
    q_snap_d = q_snap_q;
    j_d = '0;
    k_d = '0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE && cmd_valid) begin
      op_d = cmd_op;
      mask_d = cmd_mask;
      data_d = cmd_data;
      q_pre_d = q;
      cnt_d = (cmd_op == OP_COUNT && cmd_cnt != '0) ? cmd_cnt - CNT_W'(1) : '0;
      if (cmd_op == OP_HOLD || cmd_op > OP_COUNT || (cmd_op == OP_COUNT && cmd_cnt == '0)) begin
        state_d = CHECK;
        done_d = 1'b1;
        err_d = cmd_op > OP_COUNT;
        q_snap_d = q;
      end else begin
        state_d = APPLY;
        {j_d, k_d} = jk_f(cmd_op, cmd_mask, cmd_data, q);
      end
    end else if (state_q == APPLY) begin
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      if (op_q == OP_COUNT && cnt_q != '0) begin
        state_d = APPLY;
        cnt_d = cnt_q - CNT_W'(1);
        {j_d, k_d} = jk_f(op_q, mask_q, data_q, q);
      end else begin
        state_d = CHECK;
        done_d = 1'b1;
        err_d = op_q != OP_COUNT && q != exp_f(op_q, mask_q, data_q, q_pre_q);
        q_snap_d = q;
      end
    end else if (state_q == CHECK) begin
      state_d = IDLE;
    end
  end
  // state and registered outputs; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      q_pre_q <= '0;
      cnt_q <= '0;
      q_snap_q <= '0;
      j_q <= '0;
      k_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      mask_q <= mask_d;
      data_q <= data_d;
      q_pre_q <= q_pre_d;
      cnt_q <= cnt_d;
      q_snap_q <= q_snap_d;
      j_q <= j_d;
      k_q <= k_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy = ~cmd_ready;
  assign j = j_q;
  assign k = k_q;
  assign done = done_q;
  assign err = err_q;
  assign q_snap = q_snap_q;
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: directed checks of jk_bank_ctrl against a JK bank model
module tb_jk_bank_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready, busy, done, err;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_mask = '0, cmd_data = '0;
  logic [7:0] cmd_cnt = '0;
  logic [3:0] j, k, q, q_snap;
  logic [3:0] bank, ld_val = '0, stuck = '0;
  logic ld = 1'b0;
  int errors = 0, checks = 0, lat, pulses;
  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .j(j), .k(k), .q(q), .busy(busy), .done(done), .err(err), .q_snap(q_snap)
  );
  always #5 clk = ~clk;
  // JK bank: Qn = J&~Q | ~K&Q, with an optional stuck-at-0 fault on the readback
  always @(posedge clk) bank <= ld ? ld_val : (j & ~bank) | (~k & bank);
  assign q = bank & ~stuck;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [3:0] v);
    ld = 1'b1;
    ld_val = v;
    tick();
    ld = 1'b0;
  endtask
  task automatic send(input logic [2:0] op, input logic [3:0] m, input logic [3:0] d, input logic [7:0] c);
    cmd_op = op;
    cmd_mask = m;
    cmd_data = d;
    cmd_cnt = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(output int n, output int p);
    n = 1;
    p = 0;
    while (!done && n < 200) begin
      if (j != 0 || k != 0) p++;
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_jk", {j, k}, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_snap", q_snap, 0);
    preload(4'b0000);
    send(3'd1, 4'b0101, 4'b0000, 8'd0);
    chk("set_j", j, 4'b0101);
    chk("set_k", k, 4'b0000);
    chk("set_busy", busy, 1);
    wait_done(lat, pulses);
    chk("set_lat", lat, 3);
    chk("set_snap", q_snap, 4'b0101);
    chk("set_err", err, 0);
    tick();
    chk("set_done_pulse", done, 0);
    chk("set_ready", cmd_ready, 1);
    preload(4'b1111);
    send(3'd4, 4'b1111, 4'b1010, 8'd0);
    chk("load_jk", {j, k}, 8'b1010_0101);
    wait_done(lat, pulses);
    chk("load_lat", lat, 3);
    chk("load_snap", q_snap, 4'b1010);
    chk("load_err", err, 0);
    tick();
    send(3'd2, 4'b0011, 4'b0000, 8'd0);
    chk("clear_jk", {j, k}, 8'b0000_0011);
    wait_done(lat, pulses);
    chk("clear_snap", q_snap, 4'b1000);
    chk("clear_err", err, 0);
    tick();
    send(3'd3, 4'b1100, 4'b0000, 8'd0);
    chk("toggle_jk", {j, k}, 8'b1100_1100);
    wait_done(lat, pulses);
    chk("toggle_snap", q_snap, 4'b0100);
    tick();
    send(3'd0, 4'b1111, 4'b0000, 8'd0);
    wait_done(lat, pulses);
    chk("hold_lat", lat, 1);
    chk("hold_snap_err", {q_snap, err}, {4'b0100, 1'b0});
    tick();
    send(3'd6, 4'b1111, 4'b1111, 8'd0);
    wait_done(lat, pulses);
    chk("ill_lat", lat, 1);
    chk("ill_err", err, 1);
    chk("ill_jk", {j, k}, 0);
    tick();
    chk("ill_err_pulse", err, 0);
    preload(4'b0000);
    send(3'd5, 4'b1111, 4'b0000, 8'd17);
    wait_done(lat, pulses);
    chk("cnt17_lat", lat, 35);
    chk("cnt17_pulses", pulses, 17);
    chk("cnt17_snap", q_snap, 4'b0001);
    chk("cnt17_err", err, 0);
    tick();
    send(3'd5, 4'b1111, 4'b0000, 8'd0);
    chk("cnt0_jk", {j, k}, 0);
    wait_done(lat, pulses);
    chk("cnt0_lat", lat, 1);
    chk("cnt0_snap", q_snap, 4'b0001);
    tick();
    preload(4'b0100);
    send(3'd5, 4'b0011, 4'b0000, 8'd5);
    wait_done(lat, pulses);
    chk("cntm_lat", lat, 11);
    chk("cntm_snap", q_snap, 4'b0101);
    tick();
    preload(4'b0000);
    stuck = 4'b0100;
    send(3'd1, 4'b0100, 4'b0000, 8'd0);
    wait_done(lat, pulses);
    chk("stuck_err", err, 1);
    chk("stuck_snap", q_snap, 4'b0000);
    tick();
    stuck = 4'b0000;
    preload(4'b0000);
    send(3'd5, 4'b1111, 4'b0000, 8'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_jk", {j, k}, 0);
    chk("abort_bank", q, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) chk("abort_late_done", done, 0);
    end
    rst = 1'b1;
    cmd_op = 3'd1;
    cmd_mask = 4'b1111;
    cmd_valid = 1'b1;
    tick();
    chk("rstpri_ready", cmd_ready, 1);
    chk("rstpri_jk", {j, k}, 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    preload(4'b0000);
    cmd_op = 3'd1;
    cmd_mask = 4'b0001;
    cmd_valid = 1'b1;
    tick();
    cmd_op = 3'd3;
    cmd_mask = 4'b0010;
    chk("held_first_j", {j, k}, 8'b0001_0000);
    tick();
    tick();
    chk("held_first_done", done, 1);
    tick();
    chk("held_idle_ready", cmd_ready, 1);
    chk("held_idle_jk", {j, k}, 0);
    tick();
    cmd_valid = 1'b0;
    chk("held_second_jk", {j, k}, 8'b0010_0010);
    wait_done(lat, pulses);
    chk("held_second_lat", lat, 3);
    chk("held_second_snap", q_snap, 4'b0011);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
